uart_rx_fifo_tb: RTL and testbench
==================================

Name: uart_rx_fifo_tb

Overview:
- Testbench-side UART receiver that consumes the DUT's UART transmit pin (mprj_io[io_uart0_tx]) and buffers decoded bytes in a FIFO.
- Sits directly downstream of the chip's UART0 output, alongside the uart_tb TX driver.
- The bench pops bytes through a valid/ready port for console logging and pass/fail string checks.
- Written synthesizable so the same RTL can drive an FPGA bring-up logger.

Parameters:
- CLKS_PER_BIT, 347, clk cycles per UART bit (40 MHz / 115200 baud); 16 under high-speed simulation; legal minimum 4.
- DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  bench clock, same clock that drives the chip.
- resetb  input  1  asynchronous active-low reset.
- rxd  input  1  serial line from DUT UART TX; idle high; asynchronous to clk.
- rx_data  output  8  head-of-FIFO byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts rx_data on a cycle where rx_valid & rx_ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- busy  output  1  receiver FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte dropped because FIFO full.
- parity_err  output  1  one-cycle pulse (tied 0 unless UART_RX_PARITY_EN).

Behaviour:
- Reset (resetb=0, asynchronous assert, release synchronous to clk): FSM=IDLE; counters 0; synchronizer flops 1; FIFO empty.
  - Outputs during reset: rx_valid=0, level=0, rx_data=0, busy=0, all error pulses 0.
- Synchronizer: rxd passes through 2 flops to give rxs; all decisions use rxs, so there are 2 cycles of input latency.
- FSM states IDLE, START, DATA, STOP, BREAK. A single bit counter bc runs 0..CLKS_PER_BIT-1.
  - IDLE: on rxs 1->0, go to START with bc=0.
  - START: at bc=CLKS_PER_BIT/2-1, sample rxs. If 0, go to DATA with bc=0 and bit index 0. If 1, it was a glitch: go to IDLE with no pulse.
  - DATA: at bc=CLKS_PER_BIT-1, shift rxs into the shift register LSB-first. After bit 7, go to STOP (or PARITY when the macro is enabled).
  - STOP: at bc=CLKS_PER_BIT-1, sample rxs.
    - If 1: push the byte and go to IDLE. A new start edge is detectable on the very next cycle.
    - If 0: frame_err pulses, no push, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. Line-held-low never produces repeated frame_err.
- Push timing: the FIFO write happens on the stop-sample cycle. rx_valid and the level increment are visible on the following cycle.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(DEPTH)+1; the MSB distinguishes full from empty.
  - rx_data is driven combinationally from mem[rd_ptr].
  - Push when level==DEPTH and no pop in the same cycle: byte dropped, overrun pulses, level stays DEPTH.
  - Push and pop in the same cycle when full: both succeed, no overrun, level unchanged.
  - Pop when empty: ignored, level stays 0.
  - Simultaneous push and pop at any level: level unchanged, ordering preserved.
- Reset mid-frame: partial byte discarded, FIFO contents discarded, FSM returns to IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows bit 7 and samples one extra bit at bc=CLKS_PER_BIT-1.
  - Even parity is checked against the XOR of the 8 data bits.
  - On mismatch: parity_err pulses in the STOP-sample cycle and the byte is still pushed.
  - Stop-bit handling is unchanged.
- Undefined: 8N1 only; parity_err tied 0; no PARITY state.

Test Plan (all with CLKS_PER_BIT=16, DEPTH=16):
- Send 0x55 then 0xA3 (8N1, 16 clk/bit, rx_ready=1) -> rx_data 0x55 then 0xA3; each rx_valid pulse 1 cycle; no errors; level returns to 0.
- Hold rx_ready=0 and send 17 bytes 0x00..0x10 -> level reaches 16; overrun pulses once on byte 0x10; popping yields 0x00..0x0F in order.
- 4-cycle low glitch on rxd while idle -> FSM returns to IDLE; no push; no error pulses; busy deasserts within 10 cycles.
- Frame 0x7E with stop bit driven 0, then rxd low 100 cycles, then high -> exactly one frame_err pulse; level stays 0; next good frame 0x41 is received correctly.
- Assert resetb low at data bit 4 of a frame while level=3 -> level=0 and rx_valid=0 immediately; next frame 0x99 is received correctly.
- With UART_RX_PARITY_EN, send 0x03 with parity bit 1 -> byte 0x03 pushed; parity_err pulses once. With parity bit 0 -> no pulse.

Source files
------------

// File: rtl/uart_rx_fifo_tb.sv
// UART 8N1 receiver with 2-flop input synchronizer feeding a circular-buffer FIFO with a valid/ready pop port.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_tb #(
    parameter int CLKS_PER_BIT = 347,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     rxd,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     parity_err
);

    localparam int BCW  = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int HALF = CLKS_PER_BIT / 2 - 1;
    localparam int LAST = CLKS_PER_BIT - 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state_reg, state_next;
    logic [BCW-1:0]   bc_reg, bc_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             sync1_reg, rxs_reg, rxs_prev_reg;
    logic             push_req;
    logic             frame_err_c;
    logic             parity_err_c;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_reg, par_bad_next;
`endif

    // Synchronizer and previous-sample flop for start-edge detection; all idle high.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_reg    <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rxd;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            bc_reg      <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bc_reg      <= bc_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        bc_next      = bc_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        push_req     = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        case (state_reg)
            IDLE: begin
                bc_next = '0;
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next = START;
                end
            end
            START: begin
                // Mid-bit check rejects short low glitches on an idle line.
                if (bc_reg == BCW'(HALF)) begin
                    bc_next  = '0;
                    bit_next = '0;
                    state_next = rxs_reg ? IDLE : DATA;
                end else begin
                    bc_next = bc_reg + 1'b1;
                end
            end
            DATA: begin
                if (bc_reg == BCW'(LAST)) begin
                    bc_next    = '0;
                    shift_next = {rxs_reg, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    bc_next = bc_reg + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bc_reg == BCW'(LAST)) begin
                    bc_next      = '0;
                    par_bad_next = rxs_reg ^ (^shift_reg);
                    state_next   = STOP;
                end else begin
                    bc_next = bc_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bc_reg == BCW'(LAST)) begin
                    bc_next = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_c = par_bad_reg;
`endif
                    if (rxs_reg) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_next  = BREAK;
                    end
                end else begin
                    bc_next = bc_reg + 1'b1;
                end
            end
            BREAK: begin
                // Held-low line waits here silently so only one frame error is reported.
                if (rxs_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign frame_err  = frame_err_c;
    assign parity_err = parity_err_c;

    // FIFO: extra pointer MSB separates full from empty.
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        full, pop, push;

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign rx_valid = (wr_ptr_reg != rd_ptr_reg);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop      = rx_valid && rx_ready;
    assign push     = push_req && (!full || pop);
    assign overrun  = push_req && full && !pop;
    assign rx_data  = rx_valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_tb.sv
// Directed plus randomized bench for uart_rx_fifo_tb; expected bytes and pulse counts come from
// a frame-level model (queue of sent bytes, FIFO capacity arithmetic).
module tb_uart_rx_fifo_tb;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] level;
    logic       busy, frame_err, overrun, parity_err;

    int compares = 0;
    int fails = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, valid_cycles = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int got_idx = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_tb #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetb(resetb), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .level(level), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    // Observe the consumer port and pulse outputs mid-cycle.
    always @(negedge clk) begin
        if (resetb) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compares++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_next(input string tag, input logic [7:0] expv);
        if (got_idx < got_q.size()) begin
            check(tag, {24'h0, got_q[got_idx]}, {24'h0, expv});
            got_idx++;
        end else begin
            check({tag, "_missing"}, got_q.size(), got_idx + 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    // par < 0 means no parity bit; the stop level is left on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (par >= 0) send_bit(par[0]);
        send_bit(stop_v);
    endtask

    initial begin
        int fe0, ov0, pe0, v0, sz0, w;
        logic [7:0] b;
        logic [7:0] partial;

        // Reset state
        #3;
        check("rst_valid", rx_valid, 0);
        check("rst_level", level, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_err, overrun, parity_err}, 0);
        tick(3);
        resetb = 1'b1;
        tick(5);

        // Two back-to-back bytes with consumer always ready
        rx_ready = 1'b1;
        v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        tick(20);
        check_next("t1_byte0", 8'h55);
        check_next("t1_byte1", 8'hA3);
        check("t1_valid_cycles", valid_cycles - v0, 2);
        check("t1_errors", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        check("t1_level", level, 0);

        // Fill past capacity with consumer stalled
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, -1);
            tick(2);
            if (i == 15) begin
                check("t2_no_overrun_yet", ov_cnt - ov0, 0);
                check("t2_level_full", level, DEPTH);
            end
        end
        check("t2_overrun_once", ov_cnt - ov0, 1);
        check("t2_level_stays", level, DEPTH);
        rx_ready = 1'b1;
        tick(25);
        for (int i = 0; i < DEPTH; i++) check_next("t2_order", 8'(i));
        check("t2_level_drained", level, 0);

        // Short low glitch on an idle line
        fe0 = fe_cnt; sz0 = got_q.size();
        rxd = 1'b0;
        tick(4);
        check("t3_busy_on_glitch", busy, 1);
        rxd = 1'b1;
        w = 0;
        while (busy && w < 10) begin
            tick(1);
            w++;
        end
        check("t3_busy_cleared", busy, 0);
        tick(20);
        check("t3_no_push", got_q.size(), sz0);
        check("t3_no_ferr", fe_cnt - fe0, 0);
        check("t3_level", level, 0);

        // Bad stop bit followed by a held-low line
        fe0 = fe_cnt; sz0 = got_q.size();
        send_frame(8'h7E, 1'b0, -1);
        tick(100);
        rxd = 1'b1;
        tick(CPB);
        check("t4_ferr_once", fe_cnt - fe0, 1);
        check("t4_level", level, 0);
        check("t4_no_push", got_q.size(), sz0);
        send_frame(8'h41, 1'b1, -1);
        tick(20);
        check_next("t4_recover", 8'h41);

        // Reset in the middle of a frame with bytes buffered
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, -1);
        tick(5);
        check("t5_level3", level, 3);
        partial = 8'($urandom);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rxd = partial[4];
        tick(8);
        resetb = 1'b0;
        #1;
        check("t5_level_rst", level, 0);
        check("t5_valid_rst", rx_valid, 0);
        check("t5_busy_rst", busy, 0);
        tick(3);
        rxd = 1'b1;
        tick(2);
        resetb = 1'b1;
        tick(CPB);
        rx_ready = 1'b1;
        send_frame(8'h99, 1'b1, -1);
        tick(20);
        check_next("t5_after_reset", 8'h99);

        // Random bytes, random gaps, consumer readiness toggled per frame
        ov0 = ov_cnt; fe0 = fe_cnt;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            rx_ready = 1'($urandom_range(0, 1));
            send_frame(b, 1'b1, -1);
            tick($urandom_range(0, 20));
        end
        rx_ready = 1'b1;
        tick(30);
        foreach (exp_q[i]) check_next("t6_random", exp_q[i]);
        check("t6_level", level, 0);
        check("t6_errors", (ov_cnt - ov0) + (fe_cnt - fe0), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 has XOR 0, so parity bit 1 is wrong, 0 is right
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, 1);
        tick(20);
        check_next("t7_bad_par_byte", 8'h03);
        check("t7_perr_once", pe_cnt - pe0, 1);
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, 0);
        tick(20);
        check_next("t7_good_par_byte", 8'h03);
        check("t7_no_perr", pe_cnt - pe0, 0);
`else
        check("t7_perr_never", pe_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
